// File: rtl/simple_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// simple_bus_arb_pkg
// Shared types and widths for the simple bus arbiter and the simple_bus_if.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, GAP)
//   BUS_AW      : bus address width
//   BUS_DW      : bus data width
//   HOLD_W      : width of the saturating hold counter
// -----------------------------------------------------------------------------
package simple_bus_arb_pkg;

  localparam int BUS_AW = 8;
  localparam int BUS_DW = 8;
  localparam int HOLD_W = 4;

  // Legacy-compatible encodings, reused as the enum values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    GAP   = ST_GAP
  } arb_state_e;

endpackage

// File: rtl/simple_bus_if.sv
// -----------------------------------------------------------------------------
// simple_bus_if
// Shared simple bus: one address, one data byte and a request strobe.
//   master modport : driven by the arbiter (addr, data, req outputs)
//   slave modport  : observed by slaves and monitors (addr, data, req inputs)
// -----------------------------------------------------------------------------
interface simple_bus_if;
  import simple_bus_arb_pkg::*;

  logic [BUS_AW-1:0] addr;
  logic [BUS_DW-1:0] data;
  logic              req;

  modport master (output addr, output data, output req);
  modport slave  (input addr, input data, input req);

endinterface

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first asserted request
// found searching upward from rr_ptr_i, wrapping past N_REQ-1 back to 0.
//   req_i    : request vector
//   rr_ptr_i : index searched first
//   found_o  : at least one request is asserted
//   winner_o : index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
  output logic                     found_o,
  output logic [$clog2(N_REQ)-1:0] winner_o
);

  localparam int IDX_W = $clog2(N_REQ);

  // Rotated view of the request vector: slot gi holds request (rr_ptr + gi) mod N.
  logic [IDX_W:0]   sum [N_REQ];
  logic [IDX_W-1:0] idx [N_REQ];
  logic [N_REQ-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign sum[gi] = {1'b0, rr_ptr_i} + (IDX_W+1)'(gi);
      assign idx[gi] = (sum[gi] >= (IDX_W+1)'(N_REQ)) ?
                       IDX_W'(sum[gi] - (IDX_W+1)'(N_REQ)) : sum[gi][IDX_W-1:0];
      assign hit[gi] = req_i[idx[gi]];
    end
  endgenerate

  // Scanning from the far end lets the nearest hit overwrite the others.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found_o  = 1'b1;
        winner_o = idx[i];
      end
    end
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// simple_bus_arbiter
// Round-robin arbiter sharing one simple_bus_if among N_REQ requesters.
// An owner keeps the bus while it requests, but is released after MAX_HOLD
// cycles once someone else is waiting; a one-cycle GAP separates owners.
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   req_i   : per-requester request
//   addr_i  : packed per-requester address, slice k = [8k+7:8k]
//   data_i  : packed per-requester data, same slicing
//   gnt_o   : registered one-hot grant, zero when no owner
//   owner_o : current owner index, 0 when no owner
//   busy_o  : high in GRANT and GAP
//   bus_if  : shared bus, master side
// -----------------------------------------------------------------------------
module simple_bus_arbiter
  import simple_bus_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*BUS_AW-1:0]   addr_i,
  input  logic [N_REQ*BUS_DW-1:0]   data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [$clog2(N_REQ)-1:0]  owner_o,
  output logic                      busy_o,
  simple_bus_if.master              bus_if
);

  localparam int                IDX_W    = $clog2(N_REQ);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

  generate
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("simple_bus_arbiter: N_REQ must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("simple_bus_arbiter: MAX_HOLD must be in 1..15");
    end
  endgenerate

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  owner_mask;
  logic              owner_req;
  logic              others_req;
  logic              release_now;
  logic              bus_req;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .winner_o (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign owner_mask[gi] = (owner_q == IDX_W'(gi));
      // Grant is registered, so it is computed from the next-state values.
      assign gnt_d[gi]      = (state_d == GRANT) && (owner_d == IDX_W'(gi));
    end
  endgenerate

  assign owner_req  = req_i[owner_q];
  assign others_req = |(req_i & ~owner_mask);
  // Hold limit only forces a release when someone else is actually waiting.
  assign release_now = !owner_req || ((hold_cnt_q == HOLD_MAX) && others_req);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE, GAP: begin
        if (pick_found) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          hold_cnt_d = HOLD_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d  = GAP;
          // Advancing past the owner keeps it from winning straight back.
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = (state_q == GRANT) ? owner_q : '0;
  assign busy_o  = (state_q != IDLE);

  // Bus request follows the owner's live request, so it drops in the same
  // cycle the owner lets go, one cycle ahead of gnt_o.
  assign bus_req     = (state_q == GRANT) && owner_req;
  assign bus_if.req  = bus_req;
  assign bus_if.addr = bus_req ? addr_i[owner_q*BUS_AW +: BUS_AW] : '0;
  assign bus_if.data = bus_req ? data_i[owner_q*BUS_DW +: BUS_DW] : '0;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_bus_arbiter
// Self-checking bench for simple_bus_arbiter (N_REQ=4, MAX_HOLD=4).
// Each scenario queues the expected per-cycle outputs and compares them
// against the DUT one cycle at a time.
// -----------------------------------------------------------------------------
module tb_simple_bus_arbiter;

  logic        clk;
  logic        reset_i;
  logic [3:0]  req_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  simple_bus_if bus_sb ();

  simple_bus_arbiter #(
    .N_REQ    (4),
    .MAX_HOLD (4)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .owner_o (owner_o),
    .busy_o  (busy_o),
    .bus_if  (bus_sb)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       breq;
    logic [7:0] baddr;
    logic [7:0] bdata;
  } obs_t;

  logic [7:0] addr_tab [4];
  logic [7:0] data_tab [4];
  obs_t       exp_q [$];
  int         total_cnt = 0;
  int         bad_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] o,
                              input logic b, input logic r);
    obs_t e;
    e.gnt   = g;
    e.owner = o;
    e.busy  = b;
    e.breq  = r;
    e.baddr = r ? addr_tab[o] : 8'h00;
    e.bdata = r ? data_tab[o] : 8'h00;
    return e;
  endfunction

  function automatic obs_t exp_idle();
    return mk(4'b0000, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t exp_gap();
    return mk(4'b0000, 2'd0, 1'b1, 1'b0);
  endfunction

  function automatic obs_t exp_own(input int k, input logic r);
    return mk(4'b0001 << k, 2'(k), 1'b1, r);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.gnt   = gnt_o;
    o.owner = owner_o;
    o.busy  = busy_o;
    o.breq  = bus_sb.req;
    o.baddr = bus_sb.addr;
    o.bdata = bus_sb.data;
    return o;
  endfunction

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic drive_cycle(input logic rst, input logic [3:0] req);
    @(posedge clk);
    #1;
    reset_i = rst;
    req_i   = req;
    #1;
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 4'b0000);
  endtask

  task automatic test_reset();
    logic rs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    obs_t got, e;
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_own(0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      drive_cycle(rs[i], 4'b1111);
      got = observe();
      e   = exp_q.pop_front();
      total_cnt++;
      if (got !== e) begin
        bad_cnt++;
        $display("FAIL reset cyc=%0d got gnt=%b own=%0d busy=%b req=%b addr=%h data=%h want gnt=%b own=%0d busy=%b req=%b addr=%h data=%h",
                 i+1, got.gnt, got.owner, got.busy, got.breq, got.baddr, got.bdata,
                 e.gnt, e.owner, e.busy, e.breq, e.baddr, e.bdata);
      end else begin
        $display("txn reset cyc=%0d gnt=%b own=%0d busy=%b req=%b ok", i+1, got.gnt, got.owner, got.busy, got.breq);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] rq [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    obs_t got, e;
    do_reset();
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_own(2, 1'b1));
    exp_q.push_back(exp_own(2, 1'b1));
    exp_q.push_back(exp_own(2, 1'b1));
    exp_q.push_back(exp_own(2, 1'b0));
    exp_q.push_back(exp_gap());
    exp_q.push_back(exp_idle());
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b0, rq[i]);
      got = observe();
      e   = exp_q.pop_front();
      total_cnt++;
      if (got !== e) begin
        bad_cnt++;
        $display("FAIL single cyc=%0d got gnt=%b own=%0d busy=%b req=%b addr=%h data=%h want gnt=%b own=%0d busy=%b req=%b addr=%h data=%h",
                 i+1, got.gnt, got.owner, got.busy, got.breq, got.baddr, got.bdata,
                 e.gnt, e.owner, e.busy, e.breq, e.baddr, e.bdata);
      end else begin
        $display("txn single cyc=%0d gnt=%b own=%0d busy=%b req=%b addr=%h data=%h ok",
                 i+1, got.gnt, got.owner, got.busy, got.breq, got.baddr, got.bdata);
      end
    end
  endtask

  task automatic test_fairness();
    obs_t got, e;
    int   n;
    do_reset();
    exp_q.push_back(exp_idle());
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(exp_own(k % 4, 1'b1));
      if (k < 4) exp_q.push_back(exp_gap());
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 4'b1111);
      got = observe();
      e   = exp_q.pop_front();
      total_cnt++;
      if (got !== e) begin
        bad_cnt++;
        $display("FAIL fairness cyc=%0d got gnt=%b own=%0d busy=%b req=%b want gnt=%b own=%0d busy=%b req=%b",
                 i+1, got.gnt, got.owner, got.busy, got.breq, e.gnt, e.owner, e.busy, e.breq);
      end else begin
        $display("txn fairness cyc=%0d gnt=%b own=%0d busy=%b ok", i+1, got.gnt, got.owner, got.busy);
      end
    end
  endtask

  task automatic test_saturation();
    obs_t got, e;
    logic [3:0] rq;
    do_reset();
    exp_q.push_back(exp_idle());
    for (int j = 0; j < 7; j++) exp_q.push_back(exp_own(1, 1'b1));
    exp_q.push_back(exp_gap());
    exp_q.push_back(exp_own(3, 1'b1));
    for (int i = 0; i < 10; i++) begin
      rq = (i < 7) ? 4'b0010 : 4'b1010;
      drive_cycle(1'b0, rq);
      got = observe();
      e   = exp_q.pop_front();
      total_cnt++;
      if (got !== e) begin
        bad_cnt++;
        $display("FAIL saturation cyc=%0d got gnt=%b own=%0d busy=%b req=%b addr=%h want gnt=%b own=%0d busy=%b req=%b addr=%h",
                 i+1, got.gnt, got.owner, got.busy, got.breq, got.baddr, e.gnt, e.owner, e.busy, e.breq, e.baddr);
      end else begin
        $display("txn saturation cyc=%0d gnt=%b own=%0d busy=%b ok", i+1, got.gnt, got.owner, got.busy);
      end
    end
  endtask

  task automatic test_same_edge();
    logic [3:0] rq [10] = '{4'b0001, 4'b0101, 4'b0100, 4'b0101, 4'b0101,
                            4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    obs_t got, e;
    do_reset();
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_own(0, 1'b1));
    exp_q.push_back(exp_own(0, 1'b0));
    exp_q.push_back(exp_gap());
    for (int j = 0; j < 4; j++) exp_q.push_back(exp_own(2, 1'b1));
    exp_q.push_back(exp_gap());
    exp_q.push_back(exp_own(0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, rq[i]);
      got = observe();
      e   = exp_q.pop_front();
      total_cnt++;
      if (got !== e) begin
        bad_cnt++;
        $display("FAIL same_edge cyc=%0d got gnt=%b own=%0d busy=%b req=%b want gnt=%b own=%0d busy=%b req=%b",
                 i+1, got.gnt, got.owner, got.busy, got.breq, e.gnt, e.owner, e.busy, e.breq);
      end else begin
        $display("txn same_edge cyc=%0d gnt=%b own=%0d busy=%b ok", i+1, got.gnt, got.owner, got.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       rs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] rq [8] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000,
                           4'b1000, 4'b1001, 4'b1001, 4'b1001};
    obs_t got, e;
    do_reset();
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_own(1, 1'b1));
    exp_q.push_back(exp_own(1, 1'b0));
    exp_q.push_back(exp_gap());
    exp_q.push_back(exp_own(3, 1'b1));
    exp_q.push_back(exp_own(3, 1'b1));
    exp_q.push_back(exp_idle());
    exp_q.push_back(exp_own(0, 1'b1));
    for (int i = 0; i < 8; i++) begin
      drive_cycle(rs[i], rq[i]);
      got = observe();
      e   = exp_q.pop_front();
      total_cnt++;
      if (got !== e) begin
        bad_cnt++;
        $display("FAIL reset_mid cyc=%0d got gnt=%b own=%0d busy=%b req=%b addr=%h want gnt=%b own=%0d busy=%b req=%b addr=%h",
                 i+1, got.gnt, got.owner, got.busy, got.breq, got.baddr, e.gnt, e.owner, e.busy, e.breq, e.baddr);
      end else begin
        $display("txn reset_mid cyc=%0d gnt=%b own=%0d busy=%b ok", i+1, got.gnt, got.owner, got.busy);
      end
    end
  endtask

  initial begin
    addr_tab = '{8'hA0, 8'hB1, 8'h3C, 8'hD3};
    data_tab = '{8'h7A, 8'h6B, 8'hA5, 8'h5D};
    addr_i   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    data_i   = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
    reset_i  = 1'b1;
    req_i    = 4'b1111;

    test_reset();
    test_single();
    test_fairness();
    test_saturation();
    test_same_edge();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total_cnt, bad_cnt);
    $fatal(1, "watchdog");
  end

endmodule
